// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse-controller family of blocks.
package pulse_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_DELAY = 2'd1,
        CAP_ACCUM = 2'd2,
        CAP_LOAD  = 2'd3
    } cap_state_t;

    localparam int ADC_W_DEF     = 14;
    localparam int MAX_LOG2N_DEF = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sample_accumulator.sv
// Signed sample accumulator with sample counter; done flags the sample that completes 2^log2_n.
module sample_accumulator #(
    parameter int ADC_W     = 14,
    parameter int MAX_LOG2N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [ADC_W-1:0]          sample,
    input  logic [3:0]                log2_n,
    output logic [ADC_W+MAX_LOG2N-1:0] sum,
    output logic                      done
);

    localparam int SUM_W = ADC_W + MAX_LOG2N;
    localparam int CNT_W = MAX_LOG2N + 1;

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target;

    assign target = CNT_W'(1) << log2_n;
    assign done   = enable && (cnt_q == (target - CNT_W'(1)));
    assign sum    = sum_q;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (enable) begin
            sum_d = sum_q + {{MAX_LOG2N{sample[ADC_W-1]}}, sample};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/measure_capture.sv
// Trigger-driven settle-then-average capture with valid/ready result and miss/drop counters.
// Optional CAPTURE_TIMESTAMP_EN adds a free-running cycle counter and result_ts output.
module measure_capture
    import pulse_pkg::*;
#(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int DLY_W     = 16,
    parameter int MAX_LOG2N = MAX_LOG2N_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic [DLY_W-1:0] delay_cycles,
    input  logic [3:0]       log2_samples,
    output logic [ADC_W-1:0] result,
    output logic [7:0]       result_seq,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic [7:0]       miss_cnt,
    output logic [7:0]       drop_cnt
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    output logic [31:0]      result_ts
`endif
);

    localparam int SUM_W = ADC_W + MAX_LOG2N;
    localparam logic [3:0] MAX_K = 4'(MAX_LOG2N);

    cap_state_t       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [3:0]       k_q, k_d;
    logic [7:0]       seq_q, seq_d;
    logic [ADC_W-1:0] result_q, result_d;
    logic [7:0]       result_seq_q, result_seq_d;
    logic             result_valid_q, result_valid_d;
    logic [7:0]       miss_q, miss_d;
    logic [7:0]       drop_q, drop_d;

    logic [3:0]       k_in;
    logic             acc_clear;
    logic             acc_en;
    logic             acc_done;
    logic [SUM_W-1:0] acc_sum;
    logic [ADC_W-1:0] avg;
    logic             load_take;

    assign k_in      = (log2_samples > MAX_K) ? MAX_K : log2_samples;
    assign acc_en    = (state_q == CAP_ACCUM) && adc_valid;
    assign avg       = ADC_W'($signed(acc_sum) >>> k_q);
    assign load_take = (state_q == CAP_LOAD) && (!result_valid_q || result_ready);

    sample_accumulator #(
        .ADC_W     (ADC_W),
        .MAX_LOG2N (MAX_LOG2N)
    ) u_acc (
        .clk    (clk_in),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .enable (acc_en),
        .sample (adc_data),
        .log2_n (k_q),
        .sum    (acc_sum),
        .done   (acc_done)
    );

    always_comb begin
        state_d        = state_q;
        dly_d          = dly_q;
        k_d            = k_q;
        seq_d          = seq_q;
        result_d       = result_q;
        result_seq_d   = result_seq_q;
        result_valid_d = result_valid_q;
        miss_d         = miss_q;
        drop_d         = drop_q;
        acc_clear      = 1'b0;

        // A completed handshake frees the slot; LOAD below may refill it in the same cycle.
        if (result_valid_q && result_ready) begin
            result_valid_d = 1'b0;
        end

        if (trigger && (state_q != CAP_IDLE)) begin
            miss_d = sat_inc8(miss_q);
        end

        case (state_q)
            CAP_IDLE: begin
                if (trigger) begin
                    dly_d     = delay_cycles;
                    k_d       = k_in;
                    acc_clear = 1'b1;
                    state_d   = (delay_cycles == '0) ? CAP_ACCUM : CAP_DELAY;
                end
            end
            CAP_DELAY: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q <= DLY_W'(1)) begin
                    state_d = CAP_ACCUM;
                end
            end
            CAP_ACCUM: begin
                if (acc_done) begin
                    state_d = CAP_LOAD;
                end
            end
            CAP_LOAD: begin
                if (load_take) begin
                    result_d       = avg;
                    result_seq_d   = seq_q;
                    result_valid_d = 1'b1;
                end else begin
                    drop_d = sat_inc8(drop_q);
                end
                seq_d   = seq_q + 8'd1;
                state_d = CAP_IDLE;
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q        <= CAP_IDLE;
            dly_q          <= '0;
            k_q            <= '0;
            seq_q          <= '0;
            result_q       <= '0;
            result_seq_q   <= '0;
            result_valid_q <= 1'b0;
            miss_q         <= '0;
            drop_q         <= '0;
        end else begin
            state_q        <= state_d;
            dly_q          <= dly_d;
            k_q            <= k_d;
            seq_q          <= seq_d;
            result_q       <= result_d;
            result_seq_q   <= result_seq_d;
            result_valid_q <= result_valid_d;
            miss_q         <= miss_d;
            drop_q         <= drop_d;
        end
    end

    assign result       = result_q;
    assign result_seq   = result_seq_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q == CAP_DELAY) || (state_q == CAP_ACCUM);
    assign miss_cnt     = miss_q;
    assign drop_cnt     = drop_q;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_trig_q, ts_trig_d;
    logic [31:0] result_ts_q, result_ts_d;

    // The timestamp follows the accepted trigger and is published together with its result.
    always_comb begin
        ts_d        = ts_q + 32'd1;
        ts_trig_d   = ts_trig_q;
        result_ts_d = result_ts_q;
        if ((state_q == CAP_IDLE) && trigger) begin
            ts_trig_d = ts_q;
        end
        if (load_take) begin
            result_ts_d = ts_trig_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            ts_q        <= '0;
            ts_trig_q   <= '0;
            result_ts_q <= '0;
        end else begin
            ts_q        <= ts_d;
            ts_trig_q   <= ts_trig_d;
            result_ts_q <= result_ts_d;
        end
    end

    assign result_ts = result_ts_q;
`endif

endmodule

// File: tb/tb_measure_capture.sv
// Scoreboard bench for measure_capture: directed captures queue expected results, a monitor checks each transfer.
module tb_measure_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [13:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] delay_cycles = '0;
    logic [3:0]  log2_samples = '0;
    logic [13:0] result;
    logic [7:0]  result_seq;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;
    logic [7:0]  miss_cnt;
    logic [7:0]  drop_cnt;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] result_ts;
`endif

    always #5 clk = ~clk;

    measure_capture dut (
        .clk_in       (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .delay_cycles (delay_cycles),
        .log2_samples (log2_samples),
        .result       (result),
        .result_seq   (result_seq),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .miss_cnt     (miss_cnt),
        .drop_cnt     (drop_cnt)
`ifdef CAPTURE_TIMESTAMP_EN
        ,
        .result_ts    (result_ts)
`endif
    );

    typedef struct {
        int res;
        int seq;
        int ts;
    } exp_t;

    exp_t               sb[$];
    exp_t               mon_e;
    int                 checks = 0;
    int                 errors = 0;
    int                 seq_model = 0;
    int                 tb_cycle = 0;
    logic signed [13:0] sample_buf [0:255];

    // Reference cycle count: zero during reset, then advancing once per clock.
    always @(posedge clk) tb_cycle <= rst_n ? tb_cycle + 1 : 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every handshake transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got %0d, expected none", $signed(result));
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result", $signed(result), mon_e.res);
                checkOutput("result_seq", result_seq, mon_e.seq);
`ifdef CAPTURE_TIMESTAMP_EN
                checkOutput("result_ts", result_ts, mon_e.ts);
`endif
            end
        end
    end

    // One capture: trigger, D garbage samples during DELAY, n real samples, then timing checks.
    task automatic applyStimulus(input logic [15:0] dly, input logic [3:0] l2, input int n,
                                 input int miss_idx, input bit expect_load, input int exp_res);
        exp_t e;
        @(posedge clk); #1;
        trigger      = 1'b1;
        delay_cycles = dly;
        log2_samples = l2;
        adc_valid    = 1'b0;
        if (expect_load) begin
            e.res = exp_res;
            e.seq = seq_model % 256;
            e.ts  = tb_cycle;
            sb.push_back(e);
        end
        seq_model++;
        @(posedge clk); #1;
        trigger      = 1'b0;
        delay_cycles = 16'd9;
        log2_samples = 4'd5;
        checkOutput("busy_start", busy, 1);
        for (int i = 0; i < int'(dly); i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'sd5000;
            @(posedge clk); #1;
        end
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = sample_buf[i];
            trigger   = (i == miss_idx);
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        trigger   = 1'b0;
        checkOutput("busy_end", busy, 0);
        @(posedge clk); #1;
        checkOutput("valid_at_S+2", result_valid, 1);
    endtask

    initial begin
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_result", result, 0);
        checkOutput("rst_seq", result_seq, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_miss", miss_cnt, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        // Average of 100,102,104,106 after a 3-cycle settle.
        for (int i = 0; i < 4; i++) sample_buf[i] = 14'(100 + 2 * i);
        applyStimulus(16'd3, 4'd2, 4, -1, 1'b1, 103);

        // -7 >>> 1 rounds toward -inf.
        sample_buf[0] = -14'sd3;
        sample_buf[1] = -14'sd4;
        applyStimulus(16'd0, 4'd1, 2, -1, 1'b1, -4);

        // log2=12 clamps to 256 samples: 128*7 + 128*(-8) = -128, >>> 8 = -1.
        for (int i = 0; i < 256; i++) sample_buf[i] = (i % 2 == 0) ? 14'sd7 : -14'sd8;
        applyStimulus(16'd2, 4'd12, 256, -1, 1'b1, -1);

        // Trigger during ACCUM is ignored: 101 >>> 2 = 25.
        sample_buf[0] = 14'sd10;
        sample_buf[1] = 14'sd20;
        sample_buf[2] = 14'sd30;
        sample_buf[3] = 14'sd41;
        applyStimulus(16'd1, 4'd2, 4, 2, 1'b1, 25);
        checkOutput("miss_cnt", miss_cnt, 1);

        // Reset mid-ACCUM discards the capture and clears all outputs.
        @(posedge clk); #1;
        trigger      = 1'b1;
        delay_cycles = 16'd0;
        log2_samples = 4'd3;
        @(posedge clk); #1;
        trigger   = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 14'sd33;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_result", result, 0);
        checkOutput("abort_seq", result_seq, 0);
        checkOutput("abort_valid", result_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_miss", miss_cnt, 0);
        checkOutput("abort_drop", drop_cnt, 0);
        adc_valid = 1'b0;
        rst_n     = 1'b1;
        seq_model = 0;
        @(posedge clk); #1;

        // Held result with ready low: the second capture is dropped.
        result_ready  = 1'b0;
        sample_buf[0] = 14'sd50;
        applyStimulus(16'd0, 4'd0, 1, -1, 1'b1, 50);
        sample_buf[0] = 14'sd60;
        applyStimulus(16'd0, 4'd0, 1, -1, 1'b0, 0);
        checkOutput("drop_cnt", drop_cnt, 1);
        checkOutput("held_result", $signed(result), 50);
        checkOutput("held_seq", result_seq, 0);
        @(posedge clk); #1;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        checkOutput("valid_after_xfer", result_valid, 0);

        result_ready  = 1'b1;
        sample_buf[0] = 14'sd7;
        applyStimulus(16'd0, 4'd0, 1, -1, 1'b1, 7);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/measure_capture.md
# measure_capture

Downstream consumer of the pulse controller's `trigger` strobe. For each Measure (M) pulse it waits a programmable settling delay, then accumulates 2^k signed ADC samples and produces the arithmetic-shift average with a sequence tag. The result is presented on a valid/ready handshake to the host readout path. Busy, dropped and overrun conditions are counted rather than silently lost.

## Interface
Parameters:
- `ADC_W`, 14: signed ADC sample width.
- `DLY_W`, 16: settling-delay counter width.
- `MAX_LOG2N`, 8: largest allowed log2 sample count.

Ports:
- `clk_in` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `trigger` in 1: single-cycle start strobe from the pulse controller.
- `adc_data` in `ADC_W`: signed two's-complement sample.
- `adc_valid` in 1: qualifies `adc_data`.
- `delay_cycles` in `DLY_W`: settling delay in clocks.
- `log2_samples` in 4: log2 of the sample count N; values above `MAX_LOG2N` are clamped.
- `result` out `ADC_W`: signed average.
- `result_seq` out 8: measurement sequence number.
- `result_valid` out 1: result is held and stable.
- `result_ready` in 1: consumer accepts the result.
- `busy` out 1: high in DELAY or ACCUM.
- `miss_cnt` out 8: saturating count of triggers ignored while busy.
- `drop_cnt` out 8: saturating count of results discarded because `result_valid` was still high.

## Operation
- FSM states are IDLE, DELAY, ACCUM and LOAD.
- IDLE, on `trigger`: latch `delay_cycles` into `dly_q` and clamp(`log2_samples`) into `k_q`. Clear the accumulator and sample counter. If `dly_q` is 0, go to ACCUM; otherwise go to DELAY.
- DELAY: decrement the counter each clock. On reaching 0, go to ACCUM. `adc_valid` is ignored in this state.
- ACCUM: on each `adc_valid`, add the sign-extended sample to a signed accumulator of `ADC_W+MAX_LOG2N` bits, so it cannot overflow. When the count reaches 2^`k_q`, go to LOAD.
- LOAD, single cycle:
  - Compute average = accumulator >>> `k_q`, an arithmetic shift that truncates toward −inf.
  - If `result_valid` is low, or `result_ready` is high in this same cycle, register `result` and `result_seq`, then set `result_valid`.
  - Otherwise keep the old result and increment `drop_cnt`.
  - In both cases, increment the sequence counter (mod 256) and return to IDLE.
- A `trigger` seen in DELAY, ACCUM or LOAD is ignored and increments `miss_cnt`.
- Handshake: the transfer happens on a cycle where `result_valid` and `result_ready` are both high. `result_valid` then clears the next cycle unless LOAD reloads it in that same cycle. `result`/`result_seq` are stable while valid is high.
- Counters saturate at 255 and are cleared only by reset.

## Timing
- Reset values: state IDLE; `result`, `result_seq`, `result_valid`, `busy`, `miss_cnt` and `drop_cnt` all 0; sequence counter 0.
- A `trigger` at cycle T puts the FSM in DELAY/ACCUM at T+1. `busy` goes high at T+1.
- With D = `delay_cycles`, the first sample counted is one with `adc_valid` at cycle ≥ T+1+D.
- If the last sample is accepted at cycle S: LOAD at S+1, `result_valid` high at S+2, `busy` low at S+1.
- `rst_n` low mid-capture aborts the capture on the next edge. The partial accumulation is discarded with no result, and nothing is counted.
- Configuration inputs are sampled only at trigger. Changing them mid-capture has no effect on the capture in progress.

## Configuration
- `CAPTURE_TIMESTAMP_EN`, when defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, that wraps.
  - Adds an output `result_ts` (32 bits): the counter value captured at the accepted `trigger` cycle, loaded alongside `result`.
- When undefined: no counter and no port. Behaviour is otherwise identical.

## Structure
- Package `pulse_pkg` holds:
  - the FSM state enum `cap_state_t`;
  - `ADC_W_DEF` = 14 and `MAX_LOG2N_DEF` = 8;
  - the 8-bit saturating-increment function shared with other pulse blocks.
- One sub-module, `sample_accumulator`: clear/enable/sample in, sum out, with the sample counter and a `done` flag. The FSM, delay counter, result register and handshake stay in `measure_capture`.

## Test plan
- delay_cycles=3, log2_samples=2, samples 100, 102, 104, 106 with continuous `adc_valid` → `result`=103, `result_seq`=0, `result_valid` high at S+2.
- log2_samples=1, samples −3, −4 → sum −7 >>> 1 = −4. A later log2_samples=12 clamps to 8 (256 samples), checked against the model.
- Second trigger during ACCUM → ignored, `miss_cnt`=1, first result unaffected.
- `result_ready` held low across two captures → first result retained, `drop_cnt`=1, `result_seq` of the held result = 0. Then ready high → one transfer.
- Reset asserted in the middle of ACCUM → all outputs 0 next cycle. A following capture yields `result_seq`=0.
- With `CAPTURE_TIMESTAMP_EN` defined: trigger at cycle 50 after reset → `result_ts`=50.
